// File: rtl/updown_seq_16_pkg.sv
// ---------------------------------------------------------------------------
// updown_seq_16_pkg
//   Shared definitions for the updown_seq_16 command sequencer and its
//   74x193-style counter stages: FSM state encoding, decoded command type,
//   stage width, and the command priority decoder.
// ---------------------------------------------------------------------------
package updown_seq_16_pkg;

    // Width of one cascaded counter stage (a 74x193 is a 4-bit part).
    localparam int unsigned STAGE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CNT_LO = 3'd3,
        ST_CNT_HI = 3'd4,
        ST_SETTLE = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_CLR  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_INC  = 3'd3,
        CMD_DEC  = 3'd4
    } cmd_t;

    // Priority clr > load > inc > dec. inc and dec together without clr or
    // load cancel each other and decode to no command.
    function automatic cmd_t decode_cmd(input logic inc,
                                        input logic dec,
                                        input logic load,
                                        input logic clr);
        cmd_t c;
        c = CMD_NONE;
        if (clr)
            c = CMD_CLR;
        else if (load)
            c = CMD_LOAD;
        else if (inc && !dec)
            c = CMD_INC;
        else if (dec && !inc)
            c = CMD_DEC;
        return c;
    endfunction

    // Width of a down-counter that must hold the value n (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/updown_seq_16_counter_193.sv
// ---------------------------------------------------------------------------
// updown_seq_16_counter_193
//   Behavioural model of one 74x193 synchronous 4-bit up/down counter stage.
//   Counts up on the rising edge of cpu (cpd held high), down on the rising
//   edge of cpd (cpu held high). clr is an asynchronous active-high clear and
//   has priority over npl, an asynchronous active-low parallel load.
//   Terminal-count outputs feed the clock inputs of the next stage so a chain
//   of these parts ripples carries and borrows.
//
// Ports
//   cpu   in   1  count-up clock, active edge rising
//   cpd   in   1  count-down clock, active edge rising
//   npl   in   1  asynchronous parallel load, active low
//   clr   in   1  asynchronous clear, active high
//   d     in   4  parallel load data
//   q     out  4  counter value
//   ntcu  out  1  terminal count up (low while cpu low and q == 4'hF)
//   ntcd  out  1  terminal count down (low while cpd low and q == 4'h0)
// ---------------------------------------------------------------------------
module updown_seq_16_counter_193
    import updown_seq_16_pkg::*;
(
    input  logic               cpu,
    input  logic               cpd,
    input  logic               npl,
    input  logic               clr,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q,
    output logic               ntcu,
    output logic               ntcd
);

    // cpu and cpd are never low together, so the AND of the two lines rises
    // exactly when whichever one was pulsed low is released: that is the
    // count edge of the part.
    logic cnt_clk;
    logic dir_up;

    assign cnt_clk = cpu & cpd;

    // Direction is taken on the falling edge: the line that went low is the
    // one that will produce the count edge.
    // NOTE: dir_up has no reset; it is rewritten on the falling edge that
    // precedes every count edge, so its power-up value is never used.
    always_ff @(negedge cnt_clk) begin
        dir_up <= ~cpu;
    end

    always_ff @(posedge cnt_clk or posedge clr or negedge npl) begin
        if (clr)
            q <= '0;
        else if (!npl)
            q <= d;
        else if (dir_up)
            q <= q + 4'd1;
        else
            q <= q - 4'd1;
    end

    // Borrow/carry outs follow the clock lines directly, so releasing cpu on
    // a stage at 4'hF releases ntcu at the same instant and clocks the next
    // stage as this one rolls over.
    assign ntcu = ~(~cpu & (q == 4'hF));
    assign ntcd = ~(~cpd & (q == 4'h0));

endmodule

// File: rtl/updown_seq_16.sv
// ---------------------------------------------------------------------------
// updown_seq_16
//   Synchronous command front-end for a ripple cascade of 74x193 counters.
//   Single-cycle inc/dec/load/clr commands are turned into the counters'
//   asynchronous control waveforms (cpu, cpd, npl, clr). The chain forms a
//   4*STAGES-bit register whose value is presented directly on q.
//
// Parameters
//   STAGES  number of cascaded 4-bit counter stages (register width 4*STAGES)
//   SETTLE  extra clk cycles allowed after a count edge for the ripple chain
//
// Ports
//   clk     in   1   system clock, rising edge
//   nreset  in   1   asynchronous reset, active low
//   inc     in   1   count up by 1, sampled while ready=1
//   dec     in   1   count down by 1, sampled while ready=1
//   load    in   1   parallel load of d, sampled while ready=1
//   clr     in   1   clear to 0, sampled while ready=1
//   d       in   W   parallel load data, captured when the command is taken
//   q       out  W   counter value straight from the cascade
//   ready   out  1   idle; commands are accepted only while high
//   wrap    out  1   one-cycle pulse after inc from all-ones / dec from zero
//
// Timing (command accepted at edge N)
//   inc/dec : q final and ready=1 at edge N+3+SETTLE
//   load/clr: q final and ready=1 at edge N+2+SETTLE
//   wrap    : high for the cycle just before ready returns
// ---------------------------------------------------------------------------
module updown_seq_16
    import updown_seq_16_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      load,
    input  logic                      clr,
    input  logic [STAGE_W*STAGES-1:0] d,
    output logic [STAGE_W*STAGES-1:0] q,
    output logic                      ready,
    output logic                      wrap
);

    localparam int unsigned W  = STAGE_W * STAGES;
    localparam int unsigned SW = cnt_width(SETTLE);

    state_t          state;
    state_t          state_nxt;
    cmd_t            cmd;
    logic            accept;

    logic            up_lat;       // direction of the count in flight
    logic [W-1:0]    d_lat;        // load data captured at acceptance
    logic            wrap_flag;    // count in flight crosses the modulus
    logic [SW-1:0]   settle_cnt;
    logic            ready_r;

    // Chain control lines, registered so the counters' edge-sensitive inputs
    // never see combinational glitches.
    logic            cpu_r;
    logic            cpd_r;
    logic            npl_r;
    logic            clr_r;
    logic            cpu_nxt;
    logic            cpd_nxt;
    logic            npl_nxt;
    logic            clr_nxt;

    // -----------------------------------------------------------------------
    // Next-state and control-line decode
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        cmd       = decode_cmd(inc, dec, load, clr);
        accept    = 1'b0;
        state_nxt = state;

        case (state)
            ST_IDLE: begin
                // ready_r is low for the first cycle after reset, which keeps
                // the FSM parked here until the chain is known to be cleared.
                if (ready_r && (cmd != CMD_NONE)) begin
                    accept = 1'b1;
                    case (cmd)
                        CMD_CLR:  state_nxt = ST_CLR;
                        CMD_LOAD: state_nxt = ST_LOAD;
                        default:  state_nxt = ST_CNT_LO;
                    endcase
                end
            end
            ST_CLR:    state_nxt = ST_SETTLE;
            ST_LOAD:   state_nxt = ST_SETTLE;
            ST_CNT_LO: state_nxt = ST_CNT_HI;
            ST_CNT_HI: state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == '0)
                    state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase

        // Control lines are registered from the current state, so the count
        // line falls at the end of CNT_LO and rises (the count edge) at the
        // end of CNT_HI. Only one of cpu/cpd can be low, and npl and clr come
        // from distinct states, so neither illegal combination can occur.
        cpu_nxt = ~((state == ST_CNT_LO) &&  up_lat);
        cpd_nxt = ~((state == ST_CNT_LO) && !up_lat);
        npl_nxt = ~(state == ST_LOAD);
        clr_nxt =  (state == ST_CLR);
    end

    // -----------------------------------------------------------------------
    // State, datapath and control-line registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            ready_r    <= 1'b0;
            up_lat     <= 1'b0;
            d_lat      <= '0;
            wrap_flag  <= 1'b0;
            settle_cnt <= '0;
            // Reset holds the chain cleared and every pulse line inactive,
            // aborting any count or load that was in progress.
            cpu_r      <= 1'b1;
            cpd_r      <= 1'b1;
            npl_r      <= 1'b1;
            clr_r      <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_r <= (state_nxt == ST_IDLE);
            cpu_r   <= cpu_nxt;
            cpd_r   <= cpd_nxt;
            npl_r   <= npl_nxt;
            clr_r   <= clr_nxt;

            if (accept) begin
                up_lat    <= (cmd == CMD_INC);
                wrap_flag <= 1'b0;
                if (cmd == CMD_LOAD)
                    d_lat <= d;
            end

            // q is stable during CNT_LO: the count line has not moved yet.
            if (state == ST_CNT_LO)
                wrap_flag <= up_lat ? (q == '1) : (q == '0);

            // SETTLE lasts SETTLE+1 cycles: one to finish the control pulse
            // that is still on the lines when the state is entered, plus the
            // requested settling time behind it.
            if ((state_nxt == ST_SETTLE) && (state != ST_SETTLE))
                settle_cnt <= SW'(SETTLE);
            else if ((state == ST_SETTLE) && (settle_cnt != '0))
                settle_cnt <= settle_cnt - 1'b1;
        end
    end

    assign ready = ready_r;
    assign wrap  = (state == ST_SETTLE) && (settle_cnt == '0) && wrap_flag;

    // -----------------------------------------------------------------------
    // Counter cascade: stage 0 is clocked by the FSM, stage k by the
    // terminal-count outputs of stage k-1.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic cpu_in;
        logic cpd_in;
        logic ntcu;
        logic ntcd;

        if (k == 0) begin : g_head
            assign cpu_in = cpu_r;
            assign cpd_in = cpd_r;
        end else begin : g_tail
            assign cpu_in = g_stage[k-1].ntcu;
            assign cpd_in = g_stage[k-1].ntcd;
        end

        updown_seq_16_counter_193 u_ctr (
            .cpu  (cpu_in),
            .cpd  (cpd_in),
            .npl  (npl_r),
            .clr  (clr_r),
            .d    (d_lat[STAGE_W*k +: STAGE_W]),
            .q    (q[STAGE_W*k +: STAGE_W]),
            .ntcu (ntcu),
            .ntcd (ntcd)
        );
    end

    // The last stage's carry/borrow outputs have nowhere to go.
    logic unused_tc;
    assign unused_tc = g_stage[STAGES-1].ntcu & g_stage[STAGES-1].ntcd;

endmodule
